// File: rtl/queue_arb_pkg.sv
// queue_arb_pkg: shared encodings and helpers for the queue write arbiter.
package queue_arb_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam int MAX_REQ = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/queue_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector starting one past the last winner.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic          valid,
  output logic [LW-1:0] idx,
  output logic [N-1:0]  sel
);
  // Walk offsets from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    valid = 1'b0;
    idx = last;
    sel = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[LW'((int'(last) + k) % N)]) begin
        valid = 1'b1;
        idx = LW'((int'(last) + k) % N);
      end
    end
    sel[idx] = valid;
  end
endmodule

// File: rtl/queue_write_arbiter.sv
// queue_write_arbiter: round-robin sharing of the queue write port with WRITE/WAIT pacing.
module queue_write_arbiter
  import queue_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          q_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          q_write_cmd,
  output logic [DATA_WIDTH-1:0]         q_write_data,
  output logic                          busy
);
  localparam int LW = clog2(NUM_REQ);
  logic [1:0] state;
  logic [LW-1:0] last;
  logic pick_valid;
  logic [LW-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_sel;
  logic [DATA_WIDTH-1:0] win_data;
  logic go;
  rr_pick #(.N(NUM_REQ), .LW(LW)) u_pick (
    .req(req),
    .last(last),
    .valid(pick_valid),
    .idx(pick_idx),
    .sel(pick_sel)
  );
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (pick_sel[k]) win_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end
  assign go = pick_valid && !q_full;
  // WRITE always falls into WAIT so q_full can reflect the word just written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      last <= LW'(NUM_REQ - 1);
      gnt <= '0;
      q_write_cmd <= 1'b0;
      q_write_data <= '0;
      busy <= 1'b0;
    end else if (state == ST_WRITE) begin
      state <= ST_WAIT;
      gnt <= '0;
      q_write_cmd <= 1'b0;
      busy <= 1'b1;
    end else if (go) begin
      state <= ST_WRITE;
      last <= pick_idx;
      gnt <= pick_sel;
      q_write_cmd <= 1'b1;
      q_write_data <= win_data;
      busy <= 1'b1;
    end else begin
      state <= ST_IDLE;
      gnt <= '0;
      q_write_cmd <= 1'b0;
      busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_queue_write_arbiter.sv
// tb_queue_write_arbiter: directed checks of the arbiter against a 16-deep queue model.
module tb_queue_write_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] req_data = {4'd9, 4'd7, 4'd5, 4'd3};
  logic q_full;
  logic [3:0] gnt;
  logic q_write_cmd;
  logic [3:0] q_write_data;
  logic busy;
  logic rd = 1'b0;
  int count = 0;
  int wptr = 0;
  int overflow = 0;
  logic [3:0] qlog [0:63];
  int n_checks = 0;
  int n_fail = 0;
  int g;
  int g1;

  always #5 clk = ~clk;

  queue_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_data(req_data),
    .q_full(q_full),
    .gnt(gnt),
    .q_write_cmd(q_write_cmd),
    .q_write_data(q_write_data),
    .busy(busy)
  );

  assign q_full = (count == 16);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 0;
      wptr <= 0;
    end else begin
      if (q_write_cmd && count == 16) overflow <= overflow + 1;
      if (q_write_cmd && count < 16) begin
        qlog[wptr] <= q_write_data;
        wptr <= wptr + 1;
      end
      count <= count + ((q_write_cmd && count < 16) ? 1 : 0) - ((rd && count > 0) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [3:0] vals [0:3];
    vals[0] = 4'd3; vals[1] = 4'd5; vals[2] = 4'd7; vals[3] = 4'd9;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_cmd", 32'(q_write_cmd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(q_write_data), 32'h0);

    // single request after reset
    req = 4'b0001;
    reset_n = 1'b1;
    step();
    chk("t1_cmd", 32'(q_write_cmd), 32'h1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_data", 32'(q_write_data), 32'h3);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step();
    chk("t1_wait_cmd", 32'(q_write_cmd), 32'h0);
    chk("t1_wait_busy", 32'(busy), 32'h1);
    step();
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_count", 32'(count), 32'h1);

    // all four held: round robin 0,1,2,3,0
    pulse_reset();
    req = 4'b1111;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(1 << (i % 4)));
      chk($sformatf("t2_data%0d", i), 32'(q_write_data), 32'(vals[i % 4]));
      if (i == 4) req = 4'b0000;
      step();
      chk($sformatf("t2_gap%0d", i), 32'({gnt, q_write_cmd}), 32'h0);
    end
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("t2_q%0d", i), 32'(qlog[i]), 32'(vals[i]));

    // fill queue from requester 2
    pulse_reset();
    req = 4'b0100;
    reset_n = 1'b1;
    g = 0;
    for (int i = 0; i < 44; i++) begin
      step();
      if (gnt[2]) g++;
    end
    chk("t3_grants", 32'(g), 32'd16);
    chk("t3_full", 32'(q_full), 32'h1);
    chk("t3_overflow", 32'(overflow), 32'h0);
    chk("t3_gnt_blocked", 32'(gnt), 32'h0);
    rd = 1'b1;
    step();
    rd = 1'b0;
    g = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt[2]) g++;
    end
    chk("t3_regrant", 32'(g), 32'd1);
    chk("t3_refull", 32'(q_full), 32'h1);
    chk("t3_overflow2", 32'(overflow), 32'h0);
    req = 4'b0000;

    // wrap-around from last=1
    pulse_reset();
    req = 4'b0010;
    reset_n = 1'b1;
    step();
    chk("t4_first", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    req = 4'b1010;
    step();
    chk("t4_gnt3", 32'(gnt), 32'h8);
    chk("t4_data3", 32'(q_write_data), 32'h9);
    req = 4'b0010;
    step();
    chk("t4_wait", 32'(gnt), 32'h0);
    step();
    chk("t4_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;

    // asynchronous reset during WRITE
    pulse_reset();
    req = 4'b0110;
    reset_n = 1'b1;
    step();
    chk("t5_pre", 32'(gnt), 32'h2);
    reset_n = 1'b0;
    #1;
    chk("t5_async", 32'({gnt, q_write_cmd, busy}), 32'h0);
    chk("t5_data", 32'(q_write_data), 32'h0);
    req = 4'b0111;
    step();
    reset_n = 1'b1;
    step();
    chk("t5_after", 32'(gnt), 32'h1);
    req = 4'b0000;

    // requester 1 drops before its turn
    pulse_reset();
    req = 4'b0111;
    reset_n = 1'b1;
    step();
    chk("t6_gnt0", 32'(gnt), 32'h1);
    req = 4'b0101;
    g1 = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (gnt[1]) g1++;
    end
    chk("t6_gnt2", 32'(gnt), 32'h4);
    chk("t6_data2", 32'(q_write_data), 32'h7);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      if (gnt[1]) g1++;
    end
    chk("t6_no_gnt1", 32'(g1), 32'd0);
    chk("t6_writes", 32'(wptr), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
